// File: rtl/decode_stage_p_if.sv
// Bus interface for decode_stage_p: decode-side inputs, writeback port,
// stall outputs and the ID/EX register outputs.
// master = upstream/surrounding pipeline, slave = the decode stage itself.
interface decode_stage_p_if #(
    parameter int XLEN   = 16,
    parameter int CTRL_W = 12
);
    logic [15:0]       instr_d;
    logic              valid_d;
    logic [XLEN-1:0]   pc_d;
    logic [XLEN-1:0]   pc_plus_d;
    logic [CTRL_W-1:0] ctrl_d;
    logic              a2src_d;
    logic              uses_rs2_d;
    logic              wb_en_w;
    logic [2:0]        wb_addr_w;
    logic [XLEN-1:0]   wb_data_w;
    logic              flush_e_i;
    logic              stall_f;
    logic              stall_d;
    logic              valid_e;
    logic [CTRL_W-1:0] ctrl_e;
    logic [XLEN-1:0]   rd1_e;
    logic [XLEN-1:0]   rd2_e;
    logic [XLEN-1:0]   imm_e;
    logic [XLEN-1:0]   pc_e;
    logic [XLEN-1:0]   pc_plus_e;
    logic [2:0]        rs1_e;
    logic [2:0]        rs2_e;
    logic [2:0]        rd_e;
    logic [2:0]        funct3_e;

    modport master (
        output instr_d, valid_d, pc_d, pc_plus_d, ctrl_d, a2src_d, uses_rs2_d,
        output wb_en_w, wb_addr_w, wb_data_w, flush_e_i,
        input  stall_f, stall_d, valid_e, ctrl_e, rd1_e, rd2_e, imm_e,
        input  pc_e, pc_plus_e, rs1_e, rs2_e, rd_e, funct3_e
    );

    modport slave (
        input  instr_d, valid_d, pc_d, pc_plus_d, ctrl_d, a2src_d, uses_rs2_d,
        input  wb_en_w, wb_addr_w, wb_data_w, flush_e_i,
        output stall_f, stall_d, valid_e, ctrl_e, rd1_e, rd2_e, imm_e,
        output pc_e, pc_plus_e, rs1_e, rs2_e, rd_e, funct3_e
    );
endinterface

// File: rtl/decode_stage_p.sv
// Decode stage of the 16-bit pipelined CPU: 8-entry register file,
// ID/EX pipeline register (valid, flush-to-bubble) and load-use hazard
// detection driving the fetch/decode stall.
// Optional feature: define DECODE_BYPASS_EN for write-first register reads
// (writeback data visible to a same-cycle decode read).
module decode_stage_p #(
    parameter int XLEN    = 16,
    parameter int CTRL_W  = 12,
    parameter int RW_BIT  = 0,
    parameter int MR_BIT  = 1,
    parameter int IMM_W   = 6,
    parameter int R0_ZERO = 1
) (
    input logic             clk,
    input logic             rst,
    decode_stage_p_if.slave bus
);
    localparam bit R0Z = (R0_ZERO != 0);

    // Sign-extend the low immediate field to the datapath width.
    function automatic logic signed [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] f);
        return {{(XLEN-IMM_W){f[IMM_W-1]}}, f};
    endfunction

    // True when the address is the hard-wired zero register.
    function automatic logic is_zero_reg(input logic [2:0] a);
        return R0Z && (a == 3'd0);
    endfunction

    // Decode fields
    logic [2:0]             rs1_s, rs2_s, rd_s, f3_s;
    logic [XLEN-1:0]        rd1_s, rd2_s;
    logic signed [XLEN-1:0] imm_s;
    logic                   hz;

    // Register file state
    logic [XLEN-1:0] regs_q [8];
    logic [XLEN-1:0] regs_d [8];

    // ID/EX state
    logic                   valid_e_q, valid_e_d;
    logic [CTRL_W-1:0]      ctrl_e_q, ctrl_e_d;
    logic [XLEN-1:0]        rd1_e_q, rd1_e_d;
    logic [XLEN-1:0]        rd2_e_q, rd2_e_d;
    logic signed [XLEN-1:0] imm_e_q, imm_e_d;
    logic [XLEN-1:0]        pc_e_q, pc_e_d;
    logic [XLEN-1:0]        pc_plus_e_q, pc_plus_e_d;
    logic [2:0]             rs1_e_q, rs1_e_d;
    logic [2:0]             rs2_e_q, rs2_e_d;
    logic [2:0]             rd_e_q, rd_e_d;
    logic [2:0]             funct3_e_q, funct3_e_d;

    // Opcode bits are consumed by the external decoder; the regwrite bit is
    // only carried through to execute.
    logic unused_bits;
    assign unused_bits = ^{bus.instr_d[15:12], bus.ctrl_d[RW_BIT]};

    assign rs1_s = bus.instr_d[8:6];
    assign rd_s  = bus.instr_d[11:9];
    assign rs2_s = bus.a2src_d ? bus.instr_d[11:9] : bus.instr_d[5:3];
    assign f3_s  = bus.instr_d[2:0];
    assign imm_s = sext_imm(bus.instr_d[IMM_W-1:0]);

    // Combinational register reads, zero register forced to 0
    always_comb begin
        rd1_s = regs_q[rs1_s];
        rd2_s = regs_q[rs2_s];
`ifdef DECODE_BYPASS_EN
        if (bus.wb_en_w && !is_zero_reg(bus.wb_addr_w)) begin
            if (bus.wb_addr_w == rs1_s) rd1_s = bus.wb_data_w;
            if (bus.wb_addr_w == rs2_s) rd2_s = bus.wb_data_w;
        end
`endif
        if (is_zero_reg(rs1_s)) rd1_s = '0;
        if (is_zero_reg(rs2_s)) rd2_s = '0;
    end

    // Next register file contents from the writeback port
    always_comb begin
        regs_d = regs_q;
        if (bus.wb_en_w && !is_zero_reg(bus.wb_addr_w))
            regs_d[bus.wb_addr_w] = bus.wb_data_w;
    end

    // Load-use hazard: load in execute whose destination a decode source needs
    always_comb begin
        hz = bus.valid_d && valid_e_q && ctrl_e_q[MR_BIT]
             && ((rd_e_q != 3'd0) || !R0Z)
             && ((rd_e_q == rs1_s) || (bus.uses_rs2_d && (rd_e_q == rs2_s)));
    end

    assign bus.stall_f = hz && !bus.flush_e_i;
    assign bus.stall_d = hz && !bus.flush_e_i;

    // ID/EX next state: flush or hazard load a bubble, otherwise capture decode
    always_comb begin
        valid_e_d   = 1'b0;
        ctrl_e_d    = '0;
        rd1_e_d     = '0;
        rd2_e_d     = '0;
        imm_e_d     = '0;
        pc_e_d      = '0;
        pc_plus_e_d = '0;
        rs1_e_d     = '0;
        rs2_e_d     = '0;
        rd_e_d      = '0;
        funct3_e_d  = '0;
        if (!bus.flush_e_i && !hz) begin
            valid_e_d   = bus.valid_d;
            ctrl_e_d    = bus.valid_d ? bus.ctrl_d : '0;
            rd1_e_d     = rd1_s;
            rd2_e_d     = rd2_s;
            imm_e_d     = imm_s;
            pc_e_d      = bus.pc_d;
            pc_plus_e_d = bus.pc_plus_d;
            rs1_e_d     = rs1_s;
            rs2_e_d     = rs2_s;
            rd_e_d      = rd_s;
            funct3_e_d  = f3_s;
        end
    end

    // Register file storage, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // ID/EX pipeline register, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_e_q   <= 1'b0;
            ctrl_e_q    <= '0;
            rd1_e_q     <= '0;
            rd2_e_q     <= '0;
            imm_e_q     <= '0;
            pc_e_q      <= '0;
            pc_plus_e_q <= '0;
            rs1_e_q     <= '0;
            rs2_e_q     <= '0;
            rd_e_q      <= '0;
            funct3_e_q  <= '0;
        end else begin
            valid_e_q   <= valid_e_d;
            ctrl_e_q    <= ctrl_e_d;
            rd1_e_q     <= rd1_e_d;
            rd2_e_q     <= rd2_e_d;
            imm_e_q     <= imm_e_d;
            pc_e_q      <= pc_e_d;
            pc_plus_e_q <= pc_plus_e_d;
            rs1_e_q     <= rs1_e_d;
            rs2_e_q     <= rs2_e_d;
            rd_e_q      <= rd_e_d;
            funct3_e_q  <= funct3_e_d;
        end
    end

    assign bus.valid_e   = valid_e_q;
    assign bus.ctrl_e    = ctrl_e_q;
    assign bus.rd1_e     = rd1_e_q;
    assign bus.rd2_e     = rd2_e_q;
    assign bus.imm_e     = imm_e_q;
    assign bus.pc_e      = pc_e_q;
    assign bus.pc_plus_e = pc_plus_e_q;
    assign bus.rs1_e     = rs1_e_q;
    assign bus.rs2_e     = rs2_e_q;
    assign bus.rd_e      = rd_e_q;
    assign bus.funct3_e  = funct3_e_q;
endmodule

// File: tb/tb_decode_stage_p.sv
// Testbench for decode_stage_p: directed stimulus with literal expectations
// plus a behavioural reference model compared on every falling clock edge.
module tb_decode_stage_p;
    localparam int XLEN = 16;
    localparam int CW   = 12;
    localparam logic [CW-1:0] C_ALU  = 12'h001;
    localparam logic [CW-1:0] C_LOAD = 12'h003;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    decode_stage_p_if #(.XLEN(XLEN), .CTRL_W(CW)) bus ();

    decode_stage_p #(
        .XLEN(XLEN), .CTRL_W(CW), .RW_BIT(0), .MR_BIT(1), .IMM_W(6), .R0_ZERO(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0]   m_regs [8];
    logic          m_valid;
    logic [CW-1:0] m_ctrl;
    logic [15:0]   m_rd1, m_rd2, m_imm, m_pc, m_pcp;
    logic [2:0]    m_rs1, m_rs2, m_rd, m_f3;

    function automatic logic [2:0] f_rs1(input logic [15:0] ins);
        return ins[8:6];
    endfunction
    function automatic logic [2:0] f_rs2(input logic [15:0] ins, input logic a2);
        return a2 ? ins[11:9] : ins[5:3];
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] a);
        if (a == 3'd0) return 16'h0000;
`ifdef DECODE_BYPASS_EN
        if (bus.wb_en_w && bus.wb_addr_w == a) return bus.wb_data_w;
`endif
        return m_regs[a];
    endfunction

    function automatic logic m_stall();
        logic dep;
        dep = (m_rd == f_rs1(bus.instr_d)) ||
              (bus.uses_rs2_d && m_rd == f_rs2(bus.instr_d, bus.a2src_d));
        return bus.valid_d && m_valid && m_ctrl[1] && (m_rd != 3'd0) && dep
               && !bus.flush_e_i;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
            m_valid = 1'b0; m_ctrl = '0;
            m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc = 0; m_pcp = 0;
            m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_f3 = 0;
        end else begin
            logic hazard;
            hazard = bus.valid_d && m_valid && m_ctrl[1] && (m_rd != 3'd0) &&
                     ((m_rd == f_rs1(bus.instr_d)) ||
                      (bus.uses_rs2_d && m_rd == f_rs2(bus.instr_d, bus.a2src_d)));
            if (bus.flush_e_i || hazard) begin
                m_valid = 1'b0;
                m_ctrl  = '0;
            end else begin
                m_valid = bus.valid_d;
                m_ctrl  = bus.valid_d ? bus.ctrl_d : '0;
                m_rs1   = f_rs1(bus.instr_d);
                m_rs2   = f_rs2(bus.instr_d, bus.a2src_d);
                m_rd    = bus.instr_d[11:9];
                m_f3    = bus.instr_d[2:0];
                m_rd1   = m_read(m_rs1);
                m_rd2   = m_read(m_rs2);
                m_imm   = 16'(signed'(bus.instr_d[5:0]));
                m_pc    = bus.pc_d;
                m_pcp   = bus.pc_plus_d;
            end
            if (bus.wb_en_w && bus.wb_addr_w != 3'd0) m_regs[bus.wb_addr_w] = bus.wb_data_w;
        end
    end

    // Compare DUT against model on every falling edge
    always @(negedge clk) begin
        chk("m_valid_e", 32'(bus.valid_e), 32'(m_valid));
        chk("m_ctrl_e", 32'(bus.ctrl_e), 32'(m_ctrl));
        chk("m_stall_f", 32'(bus.stall_f), 32'(rst ? m_stall() : 1'b0));
        chk("m_stall_d", 32'(bus.stall_d), 32'(rst ? m_stall() : 1'b0));
        if (m_valid) begin
            chk("m_rd1_e", 32'(bus.rd1_e), 32'(m_rd1));
            chk("m_rd2_e", 32'(bus.rd2_e), 32'(m_rd2));
            chk("m_imm_e", 32'(bus.imm_e), 32'(m_imm));
            chk("m_pc_e", 32'(bus.pc_e), 32'(m_pc));
            chk("m_pc_plus_e", 32'(bus.pc_plus_e), 32'(m_pcp));
            chk("m_rs1_e", 32'(bus.rs1_e), 32'(m_rs1));
            chk("m_rs2_e", 32'(bus.rs2_e), 32'(m_rs2));
            chk("m_rd_e", 32'(bus.rd_e), 32'(m_rd));
            chk("m_funct3_e", 32'(bus.funct3_e), 32'(m_f3));
        end
    end

    // ---------------- directed stimulus ----------------
    function automatic logic [15:0] ins(input int rd, input int rs1, input int lo6);
        logic [2:0] a, b;
        logic [5:0] c;
        a = rd[2:0]; b = rs1[2:0]; c = lo6[5:0];
        return {4'h0, a, b, c};
    endfunction

    task automatic drive(input logic [15:0] i, input logic v, input logic [CW-1:0] c,
                         input logic a2, input logic u2);
        bus.instr_d    = i;
        bus.valid_d    = v;
        bus.ctrl_d     = c;
        bus.a2src_d    = a2;
        bus.uses_rs2_d = u2;
        bus.pc_d       = {i[11:0], 4'h4};
        bus.pc_plus_d  = {i[11:0], 4'h6};
    endtask

    task automatic wb(input logic en, input logic [2:0] a, input logic [15:0] d);
        bus.wb_en_w = en; bus.wb_addr_w = a; bus.wb_data_w = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // Reset with every input at 1
        rst = 1'b0;
        drive(16'hFFFF, 1'b1, '1, 1'b1, 1'b1);
        wb(1'b1, 3'h7, 16'hFFFF);
        bus.flush_e_i = 1'b1;
        #1;
        repeat (2) step();
        chk("rst_valid_e", 32'(bus.valid_e), 32'h0);
        chk("rst_ctrl_e", 32'(bus.ctrl_e), 32'h0);
        chk("rst_rd1_e", 32'(bus.rd1_e), 32'h0);
        chk("rst_stall_f", 32'(bus.stall_f), 32'h0);

        rst = 1'b1;
        drive(16'h0, 1'b0, '0, 1'b0, 1'b0);
        wb(1'b0, 3'h0, 16'h0);
        bus.flush_e_i = 1'b0;
        step();
        for (int r = 0; r < 8; r++) begin
            drive(ins(0, r, 0), 1'b1, '0, 1'b0, 1'b0);
            step();
            chk("init_reg_zero", 32'(bus.rd1_e), 32'h0);
        end

        // Write r3 then read it on both ports
        drive(16'h0, 1'b0, '0, 1'b0, 1'b0);
        wb(1'b1, 3'd3, 16'h1234);
        step();
        wb(1'b0, 3'd0, 16'h0);
        drive(16'h06FF, 1'b1, C_ALU, 1'b1, 1'b1);
        step();
        chk("wr_rd1_e", 32'(bus.rd1_e), 32'h1234);
        chk("wr_rd2_e", 32'(bus.rd2_e), 32'h1234);
        chk("wr_imm_e", 32'(bus.imm_e), 32'hFFFF);
        chk("wr_valid_e", 32'(bus.valid_e), 32'h1);
        chk("wr_funct3_e", 32'(bus.funct3_e), 32'h7);

        // r0 ignores writes
        drive(16'h0, 1'b0, '0, 1'b0, 1'b0);
        wb(1'b1, 3'd0, 16'hBEEF);
        step();
        wb(1'b0, 3'd0, 16'h0);
        drive(ins(0, 0, 0), 1'b1, C_ALU, 1'b0, 1'b0);
        step();
        chk("r0_reads_zero", 32'(bus.rd1_e), 32'h0);

        // Load-use on rs1: one bubble, then capture
        drive(ins(2, 0, 0), 1'b1, C_LOAD, 1'b0, 1'b0);
        step();
        drive(ins(1, 2, 0), 1'b1, C_ALU, 1'b0, 1'b0);
        #1;
        chk("lu_stall_f", 32'(bus.stall_f), 32'h1);
        chk("lu_stall_d", 32'(bus.stall_d), 32'h1);
        step();
        chk("lu_bubble_valid", 32'(bus.valid_e), 32'h0);
        chk("lu_bubble_ctrl", 32'(bus.ctrl_e), 32'h0);
        chk("lu_stall_clear", 32'(bus.stall_f), 32'h0);
        step();
        chk("lu_capture_valid", 32'(bus.valid_e), 32'h1);
        chk("lu_capture_rs1", 32'(bus.rs1_e), 32'h2);
        chk("lu_capture_ctrl", 32'(bus.ctrl_e), 32'(C_ALU));

        // rs2 match only counts when rs2 is used
        drive(ins(2, 0, 0), 1'b1, C_LOAD, 1'b0, 1'b0);
        step();
        drive(ins(1, 1, 16), 1'b1, C_ALU, 1'b0, 1'b0);
        #1;
        chk("rs2_unused_nostall", 32'(bus.stall_f), 32'h0);
        bus.uses_rs2_d = 1'b1;
        #1;
        chk("rs2_used_stall", 32'(bus.stall_d), 32'h1);
        bus.uses_rs2_d = 1'b0;
        step();
        chk("rs2_unused_capture", 32'(bus.valid_e), 32'h1);

        // Flush wins over a hazard
        drive(ins(4, 0, 0), 1'b1, C_LOAD, 1'b0, 1'b0);
        step();
        drive(ins(1, 4, 0), 1'b1, C_ALU, 1'b0, 1'b0);
        bus.flush_e_i = 1'b1;
        #1;
        chk("fl_stall_f", 32'(bus.stall_f), 32'h0);
        step();
        chk("fl_valid_e", 32'(bus.valid_e), 32'h0);
        chk("fl_ctrl_e", 32'(bus.ctrl_e), 32'h0);
        bus.flush_e_i = 1'b0;
        step();
        chk("fl_after_valid", 32'(bus.valid_e), 32'h1);
        chk("fl_after_rs1", 32'(bus.rs1_e), 32'h4);

        // Same-cycle writeback and read of r5
        drive(16'h0, 1'b0, '0, 1'b0, 1'b0);
        wb(1'b1, 3'd5, 16'h0011);
        step();
        drive(ins(1, 5, 0), 1'b1, C_ALU, 1'b0, 1'b0);
        wb(1'b1, 3'd5, 16'h00AA);
        step();
`ifdef DECODE_BYPASS_EN
        chk("same_cycle_rd1", 32'(bus.rd1_e), 32'h00AA);
`else
        chk("same_cycle_rd1", 32'(bus.rd1_e), 32'h0011);
`endif
        wb(1'b0, 3'd0, 16'h0);
        step();
        chk("after_wb_rd1", 32'(bus.rd1_e), 32'h00AA);

        // Asynchronous reset mid-cycle with a valid instruction in execute
        chk("pre_rst_valid", 32'(bus.valid_e), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.valid_e), 32'h0);
        chk("async_rst_ctrl", 32'(bus.ctrl_e), 32'h0);
        step();
        rst = 1'b1;
        drive(ins(0, 3, 0), 1'b1, C_ALU, 1'b0, 1'b0);
        step();
        chk("post_rst_r3", 32'(bus.rd1_e), 32'h0);
        chk("post_rst_valid", 32'(bus.valid_e), 32'h1);
        drive(16'h0, 1'b0, '0, 1'b0, 1'b0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
